seg_scan_ctrl: RTL and testbench

Refresh scheduler for the 8-digit multiplexed seven-segment display. Holds one 4-bit hex value per digit, written through a simple write port, and decodes each value to segments. It time-shares the segment bus round-robin among the enabled digits only. It also provides per-slot anti-ghost blanking, per-digit blinking and a frame-done strobe. Sits between the switch/register logic and the board pins AN/A2G.

---
 rtl/seg_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// -------------
// Refresh scheduler for an 8-digit multiplexed seven-segment display.
// It stores one hex nibble per digit, decodes the nibble to active-low
// segments, and shares the segment bus round-robin among the enabled digits.
// It blanks the display at the start of each slot to stop ghosting, blinks
// selected digits, and pulses frame_done each time the scan wraps.
//
// Ports
//   clk         system clock
//   resetn      synchronous active-low reset
//   wr_en       write strobe for the digit value registers
//   wr_addr     digit index to write
//   wr_data     hex value to store
//   en_mask     bit i=1: digit i takes part in the scan
//   blink_mask  bit i=1: digit i is dark while blink_phase=1
//   AN          anode enables, active-low (one-hot-low or all-high)
//   A2G         segments, active-low, bit6=a ... bit0=g
//   frame_done  one-cycle pulse when the scan wraps
//   cur_dig     index of the digit owning the current slot

module seg_scan_ctrl #(
    parameter int NDIG         = 8,
    parameter int PRESCALE     = 8192,
    parameter int BLANK        = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    wr_en,
    input  logic [$clog2(NDIG)-1:0] wr_addr,
    input  logic [3:0]              wr_data,
    input  logic [NDIG-1:0]         en_mask,
    input  logic [NDIG-1:0]         blink_mask,
    output logic [NDIG-1:0]         AN,
    output logic [6:0]              A2G,
    output logic                    frame_done,
    output logic [$clog2(NDIG)-1:0] cur_dig
);

    localparam int IW = $clog2(NDIG);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [3:0]    regs [NDIG];
    logic [PW-1:0] presc;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;

    logic          slot_end;
    logic [IW-1:0] nxt_dig;
    logic          wrap;
    logic          lit;

    // Active-low seven-segment decode, segment order a..g.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign slot_end = (presc == PW'(PRESCALE - 1));

    // Next enabled digit: search cur_dig+1 upward with wrap, cur_dig itself
    // last. Iterating from the farthest candidate down lets the nearest
    // enabled one overwrite the result. The IW-bit add wraps 7->0 for free.
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        nxt_dig = cur_dig;
        for (int k = NDIG; k >= 1; k--) begin
            if (en_mask[IW'(cur_dig + IW'(k))])
                nxt_dig = IW'(cur_dig + IW'(k));
        end
    end

    assign wrap = (nxt_dig <= cur_dig);

    // A digit is lit outside the anti-ghost window, when enabled, and when
    // not blanked by the blink phase.
    assign lit = (presc >= PW'(BLANK)) && en_mask[cur_dig]
                 && !(blink_phase && blink_mask[cur_dig]);

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            // NOTE: the digit registers are cleared on reset on purpose; the
            // display must show zeros, not garbage, after a reset.
            for (int i = 0; i < NDIG; i++) regs[i] <= 4'h0;
            presc       <= '0;
            cur_dig     <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            frame_done  <= 1'b0;
            AN          <= '1;
            A2G         <= 7'h7F;
        end else begin
            if (wr_en) regs[wr_addr] <= wr_data;

            presc <= slot_end ? '0 : presc + PW'(1);

            // With no digit enabled the scan parks and no frame completes.
            frame_done <= 1'b0;
            if (slot_end && (|en_mask)) begin
                cur_dig    <= nxt_dig;
                frame_done <= wrap;
            end

            // Count completed frames; flip the blink phase every BLINK_FRAMES.
            if (frame_done) begin
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end

            AN  <= lit ? ~(NDIG'(1) << cur_dig) : '1;
            A2G <= lit ? decode(regs[cur_dig]) : 7'h7F;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl. A cycle model pushes the expected outputs of
// every clock edge into a queue; a monitor pops and compares them half a
// cycle later. Each scenario task adds its own directed comparisons.

module tb_seg_scan_ctrl;

    localparam int PRESCALE     = 4;
    localparam int BLANK        = 1;
    localparam int BLINK_FRAMES = 2;

    logic       clk = 1'b0;
    logic       resetn;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [7:0] en_mask;
    logic [7:0] blink_mask;
    logic [7:0] AN;
    logic [6:0] A2G;
    logic       frame_done;
    logic [2:0] cur_dig;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NDIG(8), .PRESCALE(PRESCALE), .BLANK(BLANK), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .en_mask(en_mask), .blink_mask(blink_mask),
        .AN(AN), .A2G(A2G), .frame_done(frame_done), .cur_dig(cur_dig)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] a2g;
        logic       fd;
        logic [2:0] dig;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        return t[v];
    endfunction

    // ---------------- reference model ----------------
    logic [3:0] m_regs [8];
    int         m_presc, m_cur, m_fcnt;
    bit         m_phase, m_fd;

    always @(posedge clk) begin : model
        exp_t e;
        bit   lit;
        int   k, old;
        if (!resetn) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 4'h0;
            m_presc = 0; m_cur = 0; m_fcnt = 0; m_phase = 0; m_fd = 0;
            e.an = 8'hFF; e.a2g = 7'h7F; e.fd = 1'b0; e.dig = 3'd0;
        end else begin
            lit = (m_presc >= BLANK) && en_mask[m_cur] && !(m_phase && blink_mask[m_cur]);
            e.an  = lit ? ~(8'h01 << m_cur) : 8'hFF;
            e.a2g = lit ? seg_of(m_regs[m_cur]) : 7'h7F;
            if (m_fd) begin
                m_fcnt++;
                if (m_fcnt == BLINK_FRAMES) begin
                    m_fcnt  = 0;
                    m_phase = !m_phase;
                end
            end
            e.fd = 1'b0;
            if (m_presc == PRESCALE - 1 && en_mask != 8'h00) begin
                old = m_cur;
                k   = m_cur;
                do k = (k + 1) % 8; while (!en_mask[k]);
                m_cur = k;
                e.fd  = (k <= old);
            end
            m_presc = (m_presc == PRESCALE - 1) ? 0 : m_presc + 1;
            if (wr_en) m_regs[wr_addr] = wr_data;
            m_fd  = e.fd;
            e.dig = m_cur[2:0];
        end
        sb_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if ({AN, A2G, frame_done, cur_dig} !== e) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t AN=%h/%h A2G=%b/%b fd=%b/%b dig=%0d/%0d (got/want)",
                         $time, AN, e.an, A2G, e.a2g, frame_done, e.fd, cur_dig, e.dig);
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        en_mask = 8'h00; blink_mask = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (AN !== 8'hFF) begin n_fail++; $display("FAIL reset_an got %h want ff", AN); end
        n_checks++;
        if (A2G !== 7'h7F) begin n_fail++; $display("FAIL reset_a2g got %h want 7f", A2G); end
        n_checks++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got %b want 0", frame_done); end
        n_checks++;
        if (cur_dig !== 3'd0) begin n_fail++; $display("FAIL reset_dig got %0d want 0", cur_dig); end
        resetn = 1'b1;
    endtask

    task automatic test_full_scan();
        int  cnt;
        bit  found;
        @(negedge clk);
        en_mask = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = i[2:0]; wr_data = i[3:0];
            @(negedge clk);
        end
        wr_en = 1'b0;
        cnt = 0;
        repeat (64) begin
            @(negedge clk);
            if (frame_done === 1'b1) cnt++;
        end
        n_checks++;
        if (cnt != 2) begin n_fail++; $display("FAIL full_fd_count got %0d want 2", cnt); end
        found = 0;
        for (int c = 0; c < 64 && !found; c++) begin
            @(negedge clk);
            if (cur_dig === 3'd3 && AN === 8'hF7) found = 1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL full_dig3_timeout got none want AN=f7"); end
        else begin
            n_checks++;
            if (A2G !== 7'b0000110) begin n_fail++; $display("FAIL full_dig3_code got %b want 0000110", A2G); end
        end
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 4'h8;
        @(negedge clk);
        wr_en = 1'b0;
        found = 0;
        for (int c = 0; c < 64 && !found; c++) begin
            @(negedge clk);
            if (AN === 8'h7F) found = 1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL full_dig7_timeout got none want AN=7f"); end
        else begin
            n_checks++;
            if (A2G !== 7'b0000000) begin n_fail++; $display("FAIL full_eight_code got %b want 0000000", A2G); end
        end
    endtask

    task automatic test_sparse();
        int  exp_seq [3];
        int  prev, bad;
        bit  found;
        exp_seq = '{2, 7, 0};
        @(negedge clk);
        en_mask = 8'b1000_0101;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (frame_done === 1'b1) found = 1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL sparse_wrap_timeout got none want frame_done"); end
        n_checks++;
        if (cur_dig !== 3'd0) begin n_fail++; $display("FAIL sparse_wrap_dig got %0d want 0", cur_dig); end
        prev = 0;
        bad  = 0;
        for (int j = 0; j < 3; j++) begin
            found = 0;
            for (int c = 0; c < 40 && !found; c++) begin
                @(negedge clk);
                if ((~AN & ~en_mask) != 8'h00) bad++;
                if (cur_dig != prev[2:0]) found = 1;
            end
            n_checks++;
            if (!found || cur_dig !== exp_seq[j][2:0]) begin
                n_fail++;
                $display("FAIL sparse_order step %0d got %0d want %0d", j, cur_dig, exp_seq[j]);
            end
            if (j == 2) begin
                n_checks++;
                if (frame_done !== 1'b1) begin n_fail++; $display("FAIL sparse_wrap_pulse got %b want 1", frame_done); end
            end
            prev = int'(cur_dig);
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL sparse_disabled_driven got %0d want 0", bad); end
    endtask

    task automatic test_single();
        int  fd_cnt, lit_cnt, bad;
        bit  found;
        @(negedge clk);
        en_mask = 8'h10;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (cur_dig === 3'd4) found = 1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL single_timeout got %0d want 4", cur_dig); end
        repeat (4) @(negedge clk);
        fd_cnt = 0; lit_cnt = 0; bad = 0;
        repeat (16) begin
            @(negedge clk);
            if (frame_done === 1'b1) fd_cnt++;
            if (AN === 8'hEF) lit_cnt++;
            else if (AN !== 8'hFF) bad++;
            if (cur_dig !== 3'd4) bad++;
        end
        n_checks++;
        if (fd_cnt != 4) begin n_fail++; $display("FAIL single_fd_count got %0d want 4", fd_cnt); end
        n_checks++;
        if (lit_cnt != 12) begin n_fail++; $display("FAIL single_lit_count got %0d want 12", lit_cnt); end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL single_stray got %0d want 0", bad); end
    endtask

    task automatic test_blink();
        int fe_cnt, fd_cnt;
        @(negedge clk);
        en_mask = 8'h03; blink_mask = 8'h01;
        repeat (40) @(negedge clk);
        fe_cnt = 0; fd_cnt = 0;
        repeat (64) begin
            @(negedge clk);
            if (AN === 8'hFE) fe_cnt++;
            if (AN === 8'hFD) fd_cnt++;
        end
        n_checks++;
        if (fe_cnt != 12) begin n_fail++; $display("FAIL blink_dig0_lit got %0d want 12", fe_cnt); end
        n_checks++;
        if (fd_cnt != 24) begin n_fail++; $display("FAIL blink_dig1_lit got %0d want 24", fd_cnt); end
    endtask

    task automatic test_write_latency();
        logic [7:0] prev_an;
        bit         found;
        int         bad;
        @(negedge clk);
        blink_mask = 8'h00; en_mask = 8'h08;
        prev_an = AN;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (AN === 8'hF7 && prev_an === 8'hFF) found = 1;
            prev_an = AN;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL wr_sync_timeout got %h want f7", AN); end
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hF;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++;
        if (A2G !== 7'b0000110) begin n_fail++; $display("FAIL wr_too_early got %b want 0000110", A2G); end
        @(negedge clk);
        n_checks++;
        if (A2G !== 7'b0111000 || AN !== 8'hF7) begin
            n_fail++; $display("FAIL wr_latency got A2G=%b AN=%h want 0111000 f7", A2G, AN);
        end
        prev_an = AN;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (AN === 8'hF7 && prev_an === 8'hFF) found = 1;
            prev_an = AN;
        end
        en_mask = 8'h00;
        @(negedge clk);
        n_checks++;
        if (AN !== 8'hFF) begin n_fail++; $display("FAIL mask_off_an got %h want ff", AN); end
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || cur_dig !== 3'd3 || AN !== 8'hFF) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL mask_off_hold got %0d want 0", bad); end
    endtask

    task automatic test_reset_mid();
        bit found;
        @(negedge clk);
        en_mask = 8'hFF;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h5;
        @(negedge clk);
        wr_addr = 3'd7; wr_data = 4'h9;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (6) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        n_checks++;
        if (AN !== 8'hFF || A2G !== 7'h7F || cur_dig !== 3'd0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset got AN=%h A2G=%h dig=%0d fd=%b want ff 7f 0 0", AN, A2G, cur_dig, frame_done);
        end
        en_mask = 8'h01;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (AN === 8'hFE) found = 1;
        end
        n_checks++;
        if (!found || A2G !== 7'b0000001) begin
            n_fail++; $display("FAIL midreset_reg0 got %b want 0000001", A2G);
        end
        en_mask = 8'h80;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (AN === 8'h7F) found = 1;
        end
        n_checks++;
        if (!found || A2G !== 7'b0000001) begin
            n_fail++; $display("FAIL midreset_reg7 got %b want 0000001", A2G);
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_sparse();
        test_single();
        test_blink();
        test_write_latency();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
